// File: rtl/cla_seq_adder.sv
//==============================================================================
//  Module      : cla_seq_adder (with 4-bit slice cla_adder)
//  Description : Wide-operand adder that reuses one 4-bit carry-lookahead
//                slice, one nibble per clock, least-significant first.
//                Valid/ready handshake on the operand and result sides.
//                Optional macro CLA_SEQ_SUB_EN adds a 'sub' port (a - b).
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module cla_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:1] w_c;

    // Generate/propagate terms and flattened lookahead carries
    always_comb begin
        w_g    = a & b;
        w_p    = a ^ b;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
        s      = w_p ^ {w_c[3:1], cin};
        cout   = w_c[4];
    end
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s;
    logic               w_c;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_load;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign w_accept  = in_ready & in_valid;
    assign w_last    = (r_idx == IDX_W'(NSLICE - 1));

    // Subtraction stores ~b and forces the carry-in, giving a + ~b + 1
`ifdef CLA_SEQ_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    // Select the operand nibbles addressed by the slice index
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_nib = r_op_a[4*k +: 4];
                w_b_nib = r_op_b[4*k +: 4];
            end
        end
    end

    cla_adder u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept, walk all slices, then hold until consumed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then one nibble per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= a;
            r_op_b  <= w_b_load;
            r_carry <= w_carry_load;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_c;
            r_idx   <= r_idx + IDX_W'(1);
            for (int k = 0; k < NSLICE; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_sum[4*k +: 4] <= w_s;
                end
            end
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
//==============================================================================
//  Module      : tb_cla_seq_adder
//  Description : Self-checking bench for cla_seq_adder (WIDTH=16), directed
//                cases plus randomized operands against an arithmetic model.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_cla_seq_adder;
    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;

    int errors;
    int checks;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {carry-out, result} of the full-width operation
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        logic [W:0] r;
        if (sb) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return r;
    endfunction

    // One transaction: accept, walk RUN with optional noise, hold in DONE, consume
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic sb, input int hold, input bit noise, input string tag);
        logic [W:0]  exp;
        logic [63:0] mask;
        exp = model(x, y, ci, sb);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= NSLICE; k++) begin
            if (noise) begin
                in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom); sub = 1'($urandom);
            end
            @(posedge clk); @(negedge clk);
            mask = (64'd1 << (4*k)) - 64'd1;
            check({tag, ".partial"}, 64'(sum) & mask, 64'(exp[W-1:0]) & mask);
            check({tag, ".out_valid"}, 64'(out_valid), (k == NSLICE) ? 64'd1 : 64'd0);
            check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
            end
            @(posedge clk); @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_sum"}, 64'(sum), 64'(exp[W-1:0]));
        end
        check({tag, ".sum"}, 64'(sum), 64'(exp[W-1:0]));
        check({tag, ".cout"}, 64'(cout), 64'(exp[W]));
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".consumed_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".consumed_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.sum", 64'(sum), 64'd0);
        check("rst.cout", 64'(cout), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0, "d1234");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "dffff");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3, 1'b0, "dbackpr");
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 2, 1'b1, "dnoise");

        // Reset after the second RUN edge discards the operation
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.sum", 64'(sum), 64'd0);
        check("midrst.cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, "postrst");

`ifdef CLA_SEQ_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, "sub57");
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1, 1'b0, "sub75");
`endif

        for (int i = 0; i < 16; i++) begin
`ifdef CLA_SEQ_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), "rand");
`else
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
                   int'($urandom_range(0, 3)), 1'($urandom), "rand");
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
